axil_reg_slave: RTL and testbench

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

---
 rtl/axil_pkg.sv | 26 ++
 rtl/axil_reg_slave_if.sv | 58 +++++
 rtl/axil_reg_slave.sv | 139 +++++++++++++
 tb/tb_axil_reg_slave.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants and the byte-strobe merge helper.
package axil_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Bytes with a set strobe take the new value; the rest keep the old one.
  function automatic logic [AXI_DATA_W-1:0] apply_wstrb(
    input logic [AXI_DATA_W-1:0] old_data,
    input logic [AXI_DATA_W-1:0] new_data,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] res;
    res = old_data;
    for (int b = 0; b < int'(AXI_STRB_W); b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_data[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave; the master drives requests, the slave responds.
interface axil_reg_slave_if
  import axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) ();

  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]                    S_AXI_AWPROT;
  logic                          S_AXI_AWVALID;
  logic                          S_AXI_AWREADY;

  logic [AXI_DATA_W-1:0]         S_AXI_WDATA;
  logic [AXI_STRB_W-1:0]         S_AXI_WSTRB;
  logic                          S_AXI_WVALID;
  logic                          S_AXI_WREADY;

  logic [1:0]                    S_AXI_BRESP;
  logic                          S_AXI_BVALID;
  logic                          S_AXI_BREADY;

  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]                    S_AXI_ARPROT;
  logic                          S_AXI_ARVALID;
  logic                          S_AXI_ARREADY;

  logic [AXI_DATA_W-1:0]         S_AXI_RDATA;
  logic [1:0]                    S_AXI_RRESP;
  logic                          S_AXI_RVALID;
  logic                          S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS read/write 32-bit registers with per-register write pulses.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  axil_reg_slave_if.slave                        s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int unsigned IdxW = C_S_AXI_ADDR_WIDTH - 2;

  logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];

  logic                  aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [IdxW-1:0]       aw_idx_q;
  logic [AXI_DATA_W-1:0] wdata_q, rdata_q;
  logic [AXI_STRB_W-1:0] wstrb_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  awready, wready, arready;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IdxW-1:0]       aw_idx, ar_idx, cmt_idx;
  logic [AXI_DATA_W-1:0] cmt_data, rd_word;
  logic [AXI_STRB_W-1:0] cmt_strb;
  logic                  unused_bits;

  // Readies are gated by reset so they stay low while ARESETN is asserted.
  assign awready = ARESETN && !aw_held_q && !bvalid_q;
  assign wready  = ARESETN && !w_held_q && !bvalid_q;
  assign arready = ARESETN && !rvalid_q;

  assign aw_hs  = s_axi.S_AXI_AWVALID && awready;
  assign w_hs   = s_axi.S_AXI_WVALID && wready;
  assign ar_hs  = s_axi.S_AXI_ARVALID && arready;
  assign aw_idx = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Either both halves were captured earlier, or both arrive together this edge.
  assign commit   = (aw_held_q && w_held_q) || (aw_hs && w_hs);
  assign cmt_idx  = aw_held_q ? aw_idx_q : aw_idx;
  assign cmt_data = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
  assign cmt_strb = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXI_RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= AXI_RESP_OKAY;
        // Out-of-range indices match no register and are silently dropped.
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (32'(cmt_idx) == i) begin
            regs_q[i]     <= apply_wstrb(regs_q[i], cmt_data, cmt_strb);
            wr_pulse_q[i] <= 1'b1;
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          aw_idx_q  <= aw_idx;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= s_axi.S_AXI_WDATA;
          wstrb_q  <= s_axi.S_AXI_WSTRB;
        end
        if (bvalid_q && s_axi.S_AXI_BREADY) begin
          bvalid_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == i) begin
        rd_word = regs_q[i];
      end
    end
  end

  // Reads sample regs_q before any same-edge commit lands, so they see the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= AXI_RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= AXI_RESP_OKAY;
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[i*AXI_DATA_W +: AXI_DATA_W] = regs_q[i];
    end
  end

  assign reg_wr_pulse        = wr_pulse_q;
  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized bench for axil_reg_slave against an array-based register model.
module tb_axil_reg_slave;
  import axil_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_reg_slave_if #(.C_S_AXI_ADDR_WIDTH(AW)) bus ();
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;

  axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR)
  ) dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .s_axi(bus),
    .reg_out(reg_out),
    .reg_wr_pulse(reg_wr_pulse)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] model [NR];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input int idx);
    return (idx < int'(NR)) ? model[idx] : 32'h0;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] data,
                                      input logic [3:0] strb);
    logic [31:0] mask;
    if (idx >= int'(NR)) return;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    model[idx] = (model[idx] & ~mask) | (data & mask);
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < int'(NR); i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  function automatic logic [NR-1:0] onehot(input int idx);
    logic [NR-1:0] p;
    p = '0;
    if (idx < int'(NR)) p[idx] = 1'b1;
    return p;
  endfunction

  task automatic drive_idle();
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  // AW raised after aw_gap cycles, W after w_gap; BREADY held off for b_wait cycles.
  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_gap, input int w_gap,
                          input int b_wait);
    int cyc, aw_edge, w_edge, idx;
    bit aw_done, w_done, aw_fire, w_fire;
    idx = int'(addr >> 2);
    cyc = 0; aw_done = 0; w_done = 0; aw_edge = -1; w_edge = -1;
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.S_AXI_AWVALID = !aw_done && (cyc >= aw_gap);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_AWPROT  = 3'($urandom);
      bus.S_AXI_WVALID  = !w_done && (cyc >= w_gap);
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      if (aw_fire) begin aw_done = 1; aw_edge = cyc; end
      if (w_fire)  begin w_done = 1;  w_edge = cyc;  end
      cyc++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check_eq("wr_handshake", {aw_done, w_done}, 2'b11);
    if (!(aw_done && w_done)) return;
    if (aw_edge == w_edge) begin
      check_eq("bvalid_same_edge", bus.S_AXI_BVALID, 1'b1);
    end else begin
      check_eq("bvalid_not_early", bus.S_AXI_BVALID, 1'b0);
      tick();
      check_eq("bvalid_after_later_hs", bus.S_AXI_BVALID, 1'b1);
    end
    model_write(idx, data, strb);
    check_eq("wr_pulse", reg_wr_pulse, onehot(idx));
    check_eq("bresp", bus.S_AXI_BRESP, AXI_RESP_OKAY);
    check_eq("reg_out_after_wr", reg_out, model_flat());
    for (int k = 0; k < b_wait; k++) begin
      tick();
      check_eq("bvalid_hold", bus.S_AXI_BVALID, 1'b1);
      check_eq("aw_w_ready_blocked", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b00);
      check_eq("wr_pulse_once_hold", reg_wr_pulse, '0);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check_eq("bvalid_cleared", bus.S_AXI_BVALID, 1'b0);
    check_eq("wr_pulse_once", reg_wr_pulse, '0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int ar_gap, input int r_wait);
    int cyc, idx;
    bit done, fire;
    logic [31:0] exp;
    idx = int'(addr >> 2);
    cyc = 0; done = 0; exp = '0;
    while (!done && cyc < 50) begin
      bus.S_AXI_ARVALID = (cyc >= ar_gap);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARPROT  = 3'($urandom);
      fire = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      exp  = model_rd(idx);
      tick();
      if (fire) done = 1;
      cyc++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    check_eq("rd_handshake", done, 1'b1);
    if (!done) return;
    check_eq("rvalid", bus.S_AXI_RVALID, 1'b1);
    check_eq("rdata", bus.S_AXI_RDATA, exp);
    check_eq("rresp", bus.S_AXI_RRESP, AXI_RESP_OKAY);
    for (int k = 0; k < r_wait; k++) begin
      tick();
      check_eq("rvalid_hold", bus.S_AXI_RVALID, 1'b1);
      check_eq("rdata_stable", bus.S_AXI_RDATA, exp);
      check_eq("arready_blocked", bus.S_AXI_ARREADY, 1'b0);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check_eq("rvalid_cleared", bus.S_AXI_RVALID, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int idx;
    drive_idle();
    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    rst_n = 1'b0;
    tick(); tick();
    check_eq("rst_readys", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    check_eq("rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    check_eq("rst_resps", {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 4'h0);
    check_eq("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    check_eq("rst_reg_out", reg_out, model_flat());
    check_eq("rst_pulse", reg_wr_pulse, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("readys_after_rst", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY},
             3'b111);

    // Basic fill and readback.
    for (int i = 0; i < 4; i++) do_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(AW'(4 * i), 0, 0);
    check_eq("fill_reg3", reg_out[127:96], 32'h4);

    // AW three cycles ahead of W, then W two cycles ahead of AW.
    do_write(AW'(4), 32'hDEADBEEF, 4'hF, 0, 3, 0);
    check_eq("aw_first_reg1", reg_out[63:32], 32'hDEADBEEF);
    do_write(AW'(4), 32'h0, 4'hF, 0, 0, 0);
    do_write(AW'(4), 32'hDEADBEEF, 4'hF, 2, 0, 0);
    check_eq("w_first_reg1", reg_out[63:32], 32'hDEADBEEF);

    // Byte strobes, including an all-zero strobe.
    do_write(AW'(8), 32'h11223344, 4'hF, 0, 0, 0);
    do_write(AW'(8), 32'hAABBCCDD, 4'b0010, 0, 0, 0);
    check_eq("strb_reg2", reg_out[95:64], 32'h1122CC44);
    do_write(AW'(8), 32'hFFFFFFFF, 4'b0000, 1, 0, 0);
    check_eq("strb0_reg2", reg_out[95:64], 32'h1122CC44);

    // Second write held off by a stalled B channel.
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = AW'(12);
    bus.S_AXI_WVALID = 1'b1;  bus.S_AXI_WDATA = 32'h33; bus.S_AXI_WSTRB = 4'hF;
    tick();
    model_write(3, 32'h33, 4'hF);
    bus.S_AXI_AWADDR = AW'(0); bus.S_AXI_WDATA = 32'h77;
    check_eq("stall_first_bvalid", bus.S_AXI_BVALID, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("stall_bvalid", bus.S_AXI_BVALID, 1'b1);
      check_eq("stall_readys", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b00);
      check_eq("stall_no_commit", reg_out, model_flat());
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check_eq("stall_b_done", bus.S_AXI_BVALID, 1'b0);
    check_eq("stall_still_old", reg_out, model_flat());
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    model_write(0, 32'h77, 4'hF);
    check_eq("second_bvalid", bus.S_AXI_BVALID, 1'b1);
    check_eq("second_pulse", reg_wr_pulse, onehot(0));
    check_eq("second_reg_out", reg_out, model_flat());
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;

    // Read and write to the same register on the same edge.
    do_write(AW'(8), 32'h5, 4'hF, 0, 0, 0);
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = AW'(8);
    bus.S_AXI_WVALID = 1'b1;  bus.S_AXI_WDATA = 32'h9; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = AW'(8);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    model_write(2, 32'h9, 4'hF);
    check_eq("rw_same_rvalid", bus.S_AXI_RVALID, 1'b1);
    check_eq("rw_same_old_data", bus.S_AXI_RDATA, 32'h5);
    check_eq("rw_same_bvalid", bus.S_AXI_BVALID, 1'b1);
    check_eq("rw_same_reg_out", reg_out, model_flat());
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    do_read(AW'(8), 0, 0);

    // Random traffic, including out-of-range indices and junk low address bits.
    for (int n = 0; n < 80; n++) begin
      idx = int'($urandom_range(0, 7));
      a = {3'(idx), 2'($urandom)};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        do_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a write (AW accepted, W not yet sent).
    do_write(AW'(0), 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    do_read(AW'(0), 0, 0);
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = AW'(0);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    check_eq("midrst_reg_out", reg_out, model_flat());
    check_eq("midrst_bvalid", bus.S_AXI_BVALID, 1'b0);
    check_eq("midrst_rdata", bus.S_AXI_RDATA, 32'h0);
    check_eq("midrst_readys", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY},
             3'b000);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("postrst_readys", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b11);
    check_eq("postrst_reg_out", reg_out, model_flat());
    do_write(AW'(4), 32'h600DF00D, 4'hF, 3, 0, 1);
    do_read(AW'(4), 0, 0);
    do_read(AW'(0), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
